// File: rtl/config_loader.sv
// Streams host config words LSB-first into a serial shift chain of CHAIN_LENGTH bits.
// One word is fetched per WAIT_WORD handshake; the load ends with a one-cycle done pulse.
module config_loader #(
  parameter int CHAIN_LENGTH = 64,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  word_valid,
  input  logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_ready,
  output logic                  shift_enable,
  output logic                  shift_out,
  output logic                  busy,
  output logic                  done
);
  localparam int TW = $clog2(CHAIN_LENGTH + 1);
  localparam int WW = $clog2(WORD_WIDTH + 1);
  localparam logic [TW-1:0] LAST_BIT  = TW'(CHAIN_LENGTH - 1);
  localparam logic [WW-1:0] LAST_WBIT = WW'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;

  state_t                state, state_nxt;
  logic [TW-1:0]         total_cnt;
  logic [WW-1:0]         word_cnt;
  logic [WORD_WIDTH-1:0] sreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // abort outranks both the word transfer and the SHIFT->DONE step
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = WAIT_WORD;
      WAIT_WORD: begin
        if (abort)           state_nxt = IDLE;
        else if (word_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (abort)                      state_nxt = IDLE;
        else if (total_cnt == LAST_BIT) state_nxt = DONE;
        else if (word_cnt == LAST_WBIT) state_nxt = WAIT_WORD;
      end
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs decode from state only, so an async reset clears them with no edge.
  always_comb begin
    word_ready   = 1'b0;
    shift_enable = 1'b0;
    shift_out    = 1'b0;
    busy         = (state != IDLE);
    done         = 1'b0;
    case (state)
      WAIT_WORD: word_ready = 1'b1;
      SHIFT: begin
        shift_enable = 1'b1;
        shift_out    = sreg[0];
      end
      DONE:      done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_cnt <= '0;
      word_cnt  <= '0;
      sreg      <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          total_cnt <= '0;
          word_cnt  <= '0;
        end
        WAIT_WORD: if (word_valid && !abort) begin
          sreg     <= word_data;
          word_cnt <= '0;
        end
        SHIFT: begin
          sreg      <= sreg >> 1;
          total_cnt <= total_cnt + 1'b1;
          word_cnt  <= word_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: three instances (40/32, 64/32, 1/32) share inputs;
// each scenario observes one instance and checks against hand-computed values.
module tb_config_loader;
  logic        clk = 1'b0;
  logic        rst, start, abort, word_valid;
  logic [31:0] word_data;
  logic [2:0]  wr, se, so, bz, dn;
  logic [31:0] words [4];
  int          cmp = 0;
  int          errs = 0;

  always #5 clk = ~clk;

  config_loader #(.CHAIN_LENGTH(40), .WORD_WIDTH(32)) u_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .word_valid(word_valid),
    .word_data(word_data), .word_ready(wr[0]), .shift_enable(se[0]), .shift_out(so[0]),
    .busy(bz[0]), .done(dn[0]));
  config_loader #(.CHAIN_LENGTH(64), .WORD_WIDTH(32)) u_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .word_valid(word_valid),
    .word_data(word_data), .word_ready(wr[1]), .shift_enable(se[1]), .shift_out(so[1]),
    .busy(bz[1]), .done(dn[1]));
  config_loader #(.CHAIN_LENGTH(1), .WORD_WIDTH(32)) u_c (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .word_valid(word_valid),
    .word_data(word_data), .word_ready(wr[2]), .shift_enable(se[2]), .shift_out(so[2]),
    .busy(bz[2]), .done(dn[2]));

  function automatic int clen(input int k);
    case (k)
      0:       return 40;
      1:       return 64;
      default: return 1;
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; abort = 1'b0; word_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Runs one load on instance k, sampling outputs 1 time unit after each edge.
  task automatic run_load(input int k, input int stall, input int abort_at, input int restart_at,
                          output int hs, output int sh, output int dn_n, output logic [63:0] stream,
                          output logic [63:0] chain, output int viol, output int stalled);
    int  cl;
    bit  fin;
    logic w, e, o, b, d;
    cl = clen(k); hs = 0; sh = 0; dn_n = 0; stream = '0; chain = '0; viol = 0; stalled = 0; fin = 0;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0; word_data = words[0]; word_valid = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      start      = (restart_at >= 0 && sh == restart_at);
      abort      = (abort_at >= 0 && sh == abort_at);
      word_data  = words[hs < 4 ? hs : 3];
      word_valid = !(hs == 1 && stalled < stall);
      w = wr[k]; e = se[k]; o = so[k]; b = bz[k]; d = dn[k];
      if (!b) begin fin = 1; break; end
      if (w && e) viol++;
      if (d && (w || e)) viol++;
      if (!e && o) viol++;
      if (w && !word_valid) stalled++;
      if (w && word_valid) hs++;
      if (e && sh < 64) begin
        stream[sh] = o;
        chain = chain >> 1;
        chain[cl-1] = o;
      end
      if (e) sh++;
      if (d) dn_n++;
    end
    if (!fin) viol += 1000;
    start = 1'b0; abort = 1'b0; word_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; abort = 1'b0; word_valid = 1'b1; word_data = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    cmp++; if (wr !== 3'b000) begin errs++; $display("FAIL reset_word_ready got=%b exp=000", wr); end
    cmp++; if (se !== 3'b000) begin errs++; $display("FAIL reset_shift_enable got=%b exp=000", se); end
    cmp++; if (so !== 3'b000) begin errs++; $display("FAIL reset_shift_out got=%b exp=000", so); end
    cmp++; if (bz !== 3'b000) begin errs++; $display("FAIL reset_busy got=%b exp=000", bz); end
    cmp++; if (dn !== 3'b000) begin errs++; $display("FAIL reset_done got=%b exp=000", dn); end
    start = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp++; if ({wr, se, so, bz, dn} !== 15'd0) begin
      errs++; $display("FAIL post_reset_idle got=%h exp=0", {wr, se, so, bz, dn});
    end
  endtask

  task automatic test_basic_40();
    int hs, sh, dn_n, viol, stl;
    logic [63:0] st, ch;
    do_reset();
    words[0] = 32'hA5A5_A5A5; words[1] = 32'h0000_00C3; words[2] = '0; words[3] = '0;
    run_load(0, 0, -1, -1, hs, sh, dn_n, st, ch, viol, stl);
    cmp++; if (hs !== 2) begin errs++; $display("FAIL a_handshakes got=%0d exp=2", hs); end
    cmp++; if (sh !== 40) begin errs++; $display("FAIL a_shifts got=%0d exp=40", sh); end
    cmp++; if (dn_n !== 1) begin errs++; $display("FAIL a_done got=%0d exp=1", dn_n); end
    cmp++; if (st[7:0] !== 8'hA5) begin errs++; $display("FAIL a_first8 got=%h exp=a5", st[7:0]); end
    cmp++; if (st !== 64'h0000_00C3_A5A5_A5A5) begin
      errs++; $display("FAIL a_stream got=%h exp=000000c3a5a5a5a5", st);
    end
    cmp++; if (ch[39:0] !== 40'hC3_A5A5_A5A5) begin
      errs++; $display("FAIL a_chain got=%h exp=c3a5a5a5a5", ch[39:0]);
    end
    cmp++; if (viol !== 0) begin errs++; $display("FAIL a_protocol got=%0d exp=0", viol); end
  endtask

  task automatic test_stall_64();
    int hs, sh, dn_n, viol, stl;
    logic [63:0] st, ch;
    do_reset();
    words[0] = 32'h1234_5678; words[1] = 32'h9ABC_DEF0; words[2] = '0; words[3] = '0;
    run_load(1, 10, -1, -1, hs, sh, dn_n, st, ch, viol, stl);
    cmp++; if (stl !== 10) begin errs++; $display("FAIL b_stall_cycles got=%0d exp=10", stl); end
    cmp++; if (hs !== 2) begin errs++; $display("FAIL b_handshakes got=%0d exp=2", hs); end
    cmp++; if (sh !== 64) begin errs++; $display("FAIL b_shifts got=%0d exp=64", sh); end
    cmp++; if (dn_n !== 1) begin errs++; $display("FAIL b_done got=%0d exp=1", dn_n); end
    cmp++; if (ch !== 64'h9ABC_DEF0_1234_5678) begin
      errs++; $display("FAIL b_chain got=%h exp=9abcdef012345678", ch);
    end
    cmp++; if (viol !== 0) begin errs++; $display("FAIL b_protocol got=%0d exp=0", viol); end
  endtask

  task automatic test_start_while_busy();
    int hs, sh, dn_n, viol, stl;
    logic [63:0] st, ch;
    do_reset();
    words[0] = 32'hDEAD_BEEF; words[1] = 32'h0F0F_3C3C; words[2] = '0; words[3] = '0;
    run_load(1, 0, -1, 20, hs, sh, dn_n, st, ch, viol, stl);
    cmp++; if (hs !== 2) begin errs++; $display("FAIL restart_handshakes got=%0d exp=2", hs); end
    cmp++; if (sh !== 64) begin errs++; $display("FAIL restart_shifts got=%0d exp=64", sh); end
    cmp++; if (dn_n !== 1) begin errs++; $display("FAIL restart_done got=%0d exp=1", dn_n); end
    cmp++; if (st !== 64'h0F0F_3C3C_DEAD_BEEF) begin
      errs++; $display("FAIL restart_stream got=%h exp=0f0f3c3cdeadbeef", st);
    end
  endtask

  task automatic test_abort();
    int hs, sh, dn_n, viol, stl;
    logic [63:0] st, ch;
    do_reset();
    words[0] = 32'hCAFE_F00D; words[1] = 32'h1357_9BDF; words[2] = '0; words[3] = '0;
    run_load(1, 0, 17, -1, hs, sh, dn_n, st, ch, viol, stl);
    // abort is raised during the 18th shift cycle, which still shifts
    cmp++; if (sh !== 18) begin errs++; $display("FAIL abort_shifts got=%0d exp=18", sh); end
    cmp++; if (dn_n !== 0) begin errs++; $display("FAIL abort_done got=%0d exp=0", dn_n); end
    cmp++; if (viol !== 0) begin errs++; $display("FAIL abort_protocol got=%0d exp=0", viol); end
    repeat (3) @(posedge clk);
    #1;
    cmp++; if (bz[1] !== 1'b0 || dn[1] !== 1'b0) begin
      errs++; $display("FAIL abort_idle got busy=%b done=%b exp=0/0", bz[1], dn[1]);
    end
    run_load(1, 0, -1, -1, hs, sh, dn_n, st, ch, viol, stl);
    cmp++; if (sh !== 64 || dn_n !== 1) begin
      errs++; $display("FAIL abort_reload got shifts=%0d done=%0d exp=64/1", sh, dn_n);
    end
    cmp++; if (ch !== 64'h1357_9BDF_CAFE_F00D) begin
      errs++; $display("FAIL abort_reload_chain got=%h exp=13579bdfcafef00d", ch);
    end
  endtask

  task automatic test_reset_mid_shift();
    bit seen, got;
    do_reset();
    words[0] = 32'hFFFF_FFFF; words[1] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b1; word_valid = 1'b1; word_data = words[0];
    @(posedge clk); #1;
    start = 1'b0;
    got = 0;
    for (int c = 0; c < 50; c++) begin
      if (se[0]) begin got = 1; break; end
      @(posedge clk); #1;
    end
    cmp++; if (!got) begin errs++; $display("FAIL rst_mid_reach_shift got=0 exp=1"); end
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    cmp++; if (se[0] !== 1'b0 || so[0] !== 1'b0) begin
      errs++; $display("FAIL rst_mid_shift_outs got se=%b so=%b exp=0/0", se[0], so[0]);
    end
    cmp++; if (bz[0] !== 1'b0 || wr[0] !== 1'b0 || dn[0] !== 1'b0) begin
      errs++; $display("FAIL rst_mid_ctrl got busy=%b ready=%b done=%b exp=0/0/0", bz[0], wr[0], dn[0]);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (dn[0] || bz[0]) seen = 1;
    end
    cmp++; if (seen) begin errs++; $display("FAIL rst_mid_no_done got=1 exp=0"); end
    word_valid = 1'b0;
  endtask

  task automatic test_chain_len_1();
    int hs, sh, dn_n, viol, stl;
    logic [63:0] st, ch;
    do_reset();
    words[0] = 32'h0000_0001; words[1] = 32'hFFFF_FFFF; words[2] = '0; words[3] = '0;
    run_load(2, 0, -1, -1, hs, sh, dn_n, st, ch, viol, stl);
    cmp++; if (hs !== 1 || sh !== 1 || dn_n !== 1) begin
      errs++; $display("FAIL c1_counts got hs=%0d sh=%0d dn=%0d exp=1/1/1", hs, sh, dn_n);
    end
    cmp++; if (st !== 64'd1) begin errs++; $display("FAIL c1_bit_one got=%h exp=1", st); end
    do_reset();
    words[0] = 32'hFFFF_FFFE;
    run_load(2, 0, -1, -1, hs, sh, dn_n, st, ch, viol, stl);
    cmp++; if (hs !== 1 || sh !== 1 || dn_n !== 1) begin
      errs++; $display("FAIL c0_counts got hs=%0d sh=%0d dn=%0d exp=1/1/1", hs, sh, dn_n);
    end
    cmp++; if (st !== 64'd0) begin errs++; $display("FAIL c0_bit_zero got=%h exp=0", st); end
    cmp++; if (viol !== 0) begin errs++; $display("FAIL c_protocol got=%0d exp=0", viol); end
  endtask

  initial begin
    word_data = '0;
    test_reset();
    test_basic_40();
    test_stall_64();
    test_start_while_busy();
    test_abort();
    test_reset_mid_shift();
    test_chain_len_1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
